// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared sizing helpers for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction
    function automatic int count_width(input int aw);
        return aw + 1;
    endfunction
endpackage

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: wrapping AddressSize-bit pointer with async reset and increment enable.
module ram_fifo_ptr #(
    parameter int AddressSize = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    output logic [AddressSize-1:0] ptr
);
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (inc) ptr <= ptr + AddressSize'(1);
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop FIFO controller driving a single-port RAM.
// Define RAM_FIFO_CTRL_ERRFLAGS_EN for sticky overflow/underflow outputs.
module ram_fifo_ctrl import ram_fifo_ctrl_pkg::*; #(
    parameter int Width = 8,
    parameter int AddressSize = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic [Width-1:0]                    push_data,
    output logic                                push_ready,
    input  logic                                pop,
    output logic [Width-1:0]                    pop_data,
    output logic                                empty,
    output logic                                full,
    output logic [count_width(AddressSize)-1:0] count,
    output logic                                ram_we,
    output logic [AddressSize-1:0]              ram_addr,
    output logic [Width-1:0]                    ram_d,
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
    output logic                                overflow,
    output logic                                underflow,
`endif
    input  logic [Width-1:0]                    ram_q
);
    localparam int CW = count_width(AddressSize);
    localparam logic [CW-1:0] DEPTH = CW'(fifo_depth(AddressSize));
    logic pop_fire, push_fire;
    logic [AddressSize-1:0] wr_ptr, rd_ptr;
    assign empty      = count == '0;
    assign full       = count == DEPTH;
    assign pop_fire   = pop & ~empty;
    // Single RAM port: a pop owns the address, so a concurrent push waits; reset blocks writes.
    assign push_ready = ~full & ~pop_fire & ~rst;
    assign push_fire  = push & push_ready;
    assign ram_we     = push_fire;
    assign ram_addr   = push_fire ? wr_ptr : rd_ptr;
    assign ram_d      = push_data;
    assign pop_data   = ram_q;
    ram_fifo_ptr #(.AddressSize(AddressSize)) u_wr (.clk(clk), .rst(rst), .inc(push_fire), .ptr(wr_ptr));
    ram_fifo_ptr #(.AddressSize(AddressSize)) u_rd (.clk(clk), .rst(rst), .inc(pop_fire), .ptr(rd_ptr));
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (push_fire) count <= count + CW'(1);
        else if (pop_fire) count <= count - CW'(1);
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized and directed checks of ram_fifo_ctrl against a queue model.
module tb_ram_fifo_ctrl;
    logic clk = 1'b0, rst = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] push_data = '0, pop_data, ram_d, ram_q;
    logic push_ready, empty, full, ram_we;
    logic [4:0] count;
    logic [3:0] ram_addr;
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
    logic overflow, underflow;
`endif
    logic [7:0] mem [16];
    logic [7:0] q [$];
    int wr_i, rd_i, errs, checks;
    bit m_ovf, m_unf;

    ram_fifo_ctrl #(.Width(8), .AddressSize(4)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .push_ready(push_ready),
        .pop(pop), .pop_data(pop_data), .empty(empty), .full(full), .count(count),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d),
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .ram_q(ram_q));

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
    assign ram_q = mem[ram_addr];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    task automatic set(input logic p, input logic [7:0] d, input logic o);
        push = p; push_data = d; pop = o;
    endtask

    // Apply the FIFO rules to the model for the current request, then cross the clock edge.
    task automatic tick();
        bit pf, pu;
        pf = pop && q.size() > 0;
        pu = push && q.size() < 16 && !pf;
        if (push && q.size() == 16) m_ovf = 1;
        if (pop && q.size() == 0) m_unf = 1;
        if (pu) begin q.push_back(push_data); wr_i = (wr_i + 1) % 16; end
        if (pf) begin void'(q.pop_front()); rd_i = (rd_i + 1) % 16; end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        set(0, 0, 0);
        rst = 1; #1; rst = 0;
        q.delete(); wr_i = 0; rd_i = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic test_reset();
        set(0, 0, 0);
        rst = 1; #1;
        checks++; if (ram_we !== 1'b0) begin errs++; $display("FAIL reset_we_during got=%b exp=0", ram_we); end
        rst = 0; #1;
        q.delete(); wr_i = 0; rd_i = 0; m_ovf = 0; m_unf = 0;
        checks++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({empty, full, push_ready, ram_we} !== 4'b1010) begin errs++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, push_ready, ram_we}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            set(1, 8'(8'h10 + i), 0); #1;
            checks++; if (ram_we !== 1'b1 || ram_addr !== 4'(i)) begin errs++; $display("FAIL fill_write[%0d] we=%b addr=%0d exp we=1 addr=%0d", i, ram_we, ram_addr, i); end
            tick();
        end
        checks++; if ({full, empty, push_ready} !== 3'b100 || count !== 5'd16) begin errs++; $display("FAIL fill_full got full/empty/ready=%b count=%0d exp 100 count=16", {full, empty, push_ready}, count); end
        set(1, 8'hEE, 0); #1;
        checks++; if (ram_we !== 1'b0) begin errs++; $display("FAIL fill_overpush_we got=%b exp=0", ram_we); end
        tick();
        checks++; if (count !== 5'd16) begin errs++; $display("FAIL fill_overpush_count got=%0d exp=16", count); end
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
        checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL overflow_set got=%b exp=1", overflow); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            set(0, 0, 1); #1;
            checks++; if (pop_data !== 8'(8'h10 + i) || ram_we !== 1'b0) begin errs++; $display("FAIL drain_data[%0d] got=%h we=%b exp=%h we=0", i, pop_data, ram_we, 8'(8'h10 + i)); end
            tick();
        end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin errs++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count); end
        set(0, 0, 1); #1; tick();
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin errs++; $display("FAIL drain_underpop got empty=%b count=%0d exp 1/0", empty, count); end
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
        checks++; if ({overflow, underflow} !== 2'b11) begin errs++; $display("FAIL flags_sticky got=%b exp=11", {overflow, underflow}); end
`endif
        set(0, 0, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin set(1, 8'($urandom), 0); #1; tick(); end
        for (int i = 0; i < 10; i++) begin set(0, 0, 1); #1; tick(); end
        for (int i = 0; i < 10; i++) begin
            set(1, 8'(8'hA0 + i), 0); #1;
            checks++; if (ram_we !== 1'b1 || ram_addr !== 4'((10 + i) % 16)) begin errs++; $display("FAIL wrap_addr[%0d] we=%b addr=%0d exp we=1 addr=%0d", i, ram_we, ram_addr, (10 + i) % 16); end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            set(0, 0, 1); #1;
            checks++; if (pop_data !== 8'(8'hA0 + i)) begin errs++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, pop_data, 8'(8'hA0 + i)); end
            tick();
        end
        set(0, 0, 0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 3; i++) begin set(1, 8'(8'h30 + i), 0); #1; tick(); end
        set(1, 8'h55, 1); #1;
        checks++; if (push_ready !== 1'b0 || ram_we !== 1'b0 || pop_data !== 8'h30) begin errs++; $display("FAIL simul_stall ready=%b we=%b data=%h exp 0/0/30", push_ready, ram_we, pop_data); end
        tick();
        checks++; if (count !== 5'd2) begin errs++; $display("FAIL simul_count got=%0d exp=2", count); end
        set(1, 8'h55, 0); #1;
        checks++; if (push_ready !== 1'b1 || ram_we !== 1'b1) begin errs++; $display("FAIL simul_retry ready=%b we=%b exp 1/1", push_ready, ram_we); end
        tick();
        checks++; if (count !== 5'd3) begin errs++; $display("FAIL simul_count2 got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            set(0, 0, 1); #1;
            checks++; if (pop_data !== (i == 2 ? 8'h55 : 8'(8'h31 + i))) begin errs++; $display("FAIL simul_order[%0d] got=%h exp=%h", i, pop_data, (i == 2 ? 8'h55 : 8'(8'h31 + i))); end
            tick();
        end
        set(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin set(1, 8'($urandom), 0); #1; tick(); end
        set(1, 8'h77, 0); #1;
        rst = 1; #1;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || ram_we !== 1'b0) begin errs++; $display("FAIL reset_mid count=%0d empty=%b we=%b exp 0/1/0", count, empty, ram_we); end
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
        checks++; if ({overflow, underflow} !== 2'b00) begin errs++; $display("FAIL flags_cleared got=%b exp=00", {overflow, underflow}); end
`endif
        set(0, 0, 0); rst = 0;
        q.delete(); wr_i = 0; rd_i = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic test_random();
        bit pf, pu;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set(1'($urandom_range(0, 99) < (n < 300 ? 70 : 35)), 8'($urandom), 1'($urandom_range(0, 99) < 50));
            #1;
            pf = pop && q.size() > 0;
            pu = push && q.size() < 16 && !pf;
            checks++; if (ram_we !== pu || push_ready !== (q.size() < 16 && !pf)) begin errs++; $display("FAIL rand_we[%0d] we=%b ready=%b exp we=%b", n, ram_we, push_ready, pu); end
            if (pu) begin
                checks++; if (ram_addr !== 4'(wr_i)) begin errs++; $display("FAIL rand_waddr[%0d] got=%0d exp=%0d", n, ram_addr, wr_i); end
            end else if (q.size() > 0) begin
                checks++; if (pop_data !== q[0]) begin errs++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, pop_data, q[0]); end
            end
            tick();
            checks++; if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 16)) begin errs++; $display("FAIL rand_state[%0d] count=%0d empty=%b full=%b exp count=%0d", n, count, empty, full, q.size()); end
`ifdef RAM_FIFO_CTRL_ERRFLAGS_EN
            checks++; if (overflow !== m_ovf || underflow !== m_unf) begin errs++; $display("FAIL rand_flags[%0d] got=%b%b exp=%b%b", n, overflow, underflow, m_ovf, m_unf); end
`endif
        end
        set(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the single-port RAM block (Width, AddressSize; ports clk, rst, we, addr, D, Q).
- Turns a push/pop stream interface into the RAM's we/addr/D strobes and returns the RAM's Q as pop data.
- Makes the RAM usable as a 2**AddressSize-deep buffer between producer and consumer stages.

Parameters:
- Width, 8, data word width; must equal the attached RAM's Width.
- AddressSize, 4, RAM address width; FIFO depth = 2**AddressSize.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  producer requests a write of push_data.
- push_data  input  Width  word to enqueue.
- push_ready  output  1  push accepted this cycle when high.
- pop  input  1  consumer requests removal of the head word.
- pop_data  output  Width  head word; valid while empty is low.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds 2**AddressSize words.
- count  output  AddressSize+1  current occupancy.
- ram_we  output  1  to RAM we.
- ram_addr  output  AddressSize  to RAM addr.
- ram_d  output  Width  to RAM D.
- ram_q  input  Width  from RAM Q (combinational read of ram_addr).

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0. No RAM writes occur during reset. RAM contents are not cleared.
- pop_fire = pop & ~empty.
- push_fire = push & push_ready.
- push_ready = ~full & ~pop_fire. The RAM is single-port, so pop has priority and a simultaneous push stalls one cycle.
- Address mux: ram_addr = rd_ptr unless push_fire, then wr_ptr.
- ram_we = push_fire; ram_d = push_data. All three are combinational.
- pop_data = ram_q whenever ram_addr = rd_ptr, i.e. always when push_fire=0. Head data is therefore visible combinationally and pop consumes it at the clock edge, giving 0-cycle read latency.
- On the clock edge:
  - push_fire: RAM writes, wr_ptr increments, count increments.
  - pop_fire: rd_ptr increments, count decrements.
  - Both cannot occur in the same cycle by construction.
- Pointers are AddressSize bits and wrap naturally from 2**AddressSize-1 to 0.
- full = (count == 2**AddressSize); empty = (count == 0).
- Write latency: a word pushed at edge N is visible on pop_data from just after edge N, once the FIFO has no other words ahead of it.
- Boundaries:
  - push while full: ignored, no RAM write, state unchanged.
  - pop while empty: ignored, pop_data undefined, state unchanged.
  - push and pop while empty: pop is not fired, push is accepted.
  - push and pop while full: pop fires, push stalls.
- rst asserted mid-operation: state returns to reset values immediately. An in-flight write is dropped because ram_we falls with rst.

Optional Feature:
- Macro RAM_FIFO_CTRL_ERRFLAGS_EN.
- Defined: adds outputs overflow and underflow, each 1 bit, sticky.
  - overflow sets on push & full.
  - underflow sets on pop & empty.
  - Both are cleared only by rst; reset value is 0.
- Undefined: these ports and registers are absent, and illegal requests are silently ignored as described above.

Decomposition:
- Shared package/header holds the depth constant derivation (2**AddressSize) and the count width (AddressSize+1). The same header includes the RAM block for integration.
- One natural sub-module: ram_fifo_ptr, a wrapping AddressSize-bit pointer with async reset and an increment enable, instantiated twice (write and read).
- count and flag logic stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 1 time unit, then 0 -> count=0, empty=1, full=0, push_ready=1, ram_we=0.
- Fill: 16 pushes of data 0x10..0x1F, Width=8, AddressSize=4 -> ram_addr 0..15 with ram_we=1 on each; after the last, full=1, count=16, push_ready=0. A 17th push causes no write.
- Drain: 16 pops after fill -> pop_data sequence 0x10..0x1F in order; then empty=1, count=0. A further pop leaves count=0.
- Wrap-around: push 10 words, pop 10, push 10 more (0xA0..0xA9) -> writes at addresses 10..15 then 0..3; pops return 0xA0..0xA9 in order.
- Simultaneous requests: with count=3, assert push (0x55) and pop together -> pop fires, push_ready=0, no write, count=2; next cycle with pop low -> push accepted, count=3.
- Reset mid-stream: with count=5 and push active, assert rst -> count=0 and empty=1 immediately, ram_we=0. With RAM_FIFO_CTRL_ERRFLAGS_EN defined, a push while full sets overflow=1, which stays high until rst.
